ans_freq_table: RTL and testbench

ANS_FREQ_TABLE -- requirements
Module: ans_freq_table

---
 rtl/ans_freq_table_pkg.sv | 26 ++
 rtl/ans_freq_table_if.sv | 44 ++++
 rtl/ans_prefix_builder.sv | 37 +++
 rtl/ans_freq_table.sv | 133 +++++++++++++
 tb/tb_ans_freq_table.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ans_freq_table_pkg.sv
// Shared widths, FSM encoding and helpers for the rANS frequency table and encoder.
package ans_freq_table_pkg;

  localparam int SYM_WIDTH   = 2;
  localparam int CNT_WIDTH   = 4;
  localparam int STATE_WIDTH = 8;
  localparam int NSYM        = 1 << SYM_WIDTH;
  localparam int ACC_WIDTH   = SYM_WIDTH + CNT_WIDTH;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_BUILD = 2'd1,
    ST_RUN   = 2'd2
  } ans_state_e;

  typedef logic [SYM_WIDTH-1:0]   sym_t;
  typedef logic [CNT_WIDTH-1:0]   cnt_t;
  typedef logic [ACC_WIDTH-1:0]   acc_t;
  typedef logic [STATE_WIDTH-1:0] tot_t;

  // Size cast zero-extends or truncates depending on the relative widths.
  function automatic tot_t fit_total(input acc_t a);
    return tot_t'(a);
  endfunction

endpackage

// File: rtl/ans_freq_table_if.sv
// Configuration, symbol stream and table-output bundle of ans_freq_table.
// sym_err exists only when ANS_ZERO_CHECK_EN is defined.
interface ans_freq_table_if;
  import ans_freq_table_pkg::*;

  logic cfg_we;
  sym_t cfg_sym;
  cnt_t cfg_count;
  logic cfg_done;
  logic cfg_clr;

  sym_t sym_in;
  logic sym_vld;
  logic sym_rdy;

  cnt_t s_count;
  acc_t s_cumulative;
  tot_t total_count;
  logic out_vld;
  logic out_rdy;
  logic table_ready;
`ifdef ANS_ZERO_CHECK_EN
  logic sym_err;
`endif

  modport master (
`ifdef ANS_ZERO_CHECK_EN
    input  sym_err,
`endif
    output cfg_we, cfg_sym, cfg_count, cfg_done, cfg_clr,
    output sym_in, sym_vld, out_rdy,
    input  sym_rdy, s_count, s_cumulative, total_count, out_vld, table_ready
  );

  modport slave (
`ifdef ANS_ZERO_CHECK_EN
    output sym_err,
`endif
    input  cfg_we, cfg_sym, cfg_count, cfg_done, cfg_clr,
    input  sym_in, sym_vld, out_rdy,
    output sym_rdy, s_count, s_cumulative, total_count, out_vld, table_ready
  );

endinterface

// File: rtl/ans_prefix_builder.sv
// Walks the table index once, accumulating the exclusive prefix sum of counts.
module ans_prefix_builder
  import ans_freq_table_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic step,
  input  cnt_t count_in,
  output sym_t index,
  output acc_t acc,
  output acc_t acc_next,
  output logic done
);

  sym_t index_reg;
  acc_t acc_reg;

  assign index    = index_reg;
  assign acc      = acc_reg;
  assign acc_next = acc_reg + acc_t'(count_in);
  assign done     = step && (index_reg == sym_t'(NSYM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_reg <= '0;
      acc_reg   <= '0;
    end else if (start) begin
      index_reg <= '0;
      acc_reg   <= '0;
    end else if (step) begin
      index_reg <= index_reg + 1'b1;
      acc_reg   <= acc_next;
    end
  end

endmodule

// File: rtl/ans_freq_table.sv
// Symbol frequency / cumulative-frequency table feeding an rANS encoder.
// Define ANS_ZERO_CHECK_EN to flag accepted symbols whose count is zero.
module ans_freq_table
  import ans_freq_table_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  input logic            ena,
  ans_freq_table_if.slave bus
);

  ans_state_e state_reg;
  cnt_t       count_mem [NSYM];
  acc_t       cum_mem   [NSYM];
  logic       out_vld_reg;
  logic       ready_reg;
  cnt_t       s_count_reg;
  acc_t       s_cum_reg;
  tot_t       total_reg;
`ifdef ANS_ZERO_CHECK_EN
  logic       sym_err_reg;
`endif

  logic load_we;
  logic start;
  logic step;
  logic done;
  logic accept;
  sym_t build_idx;
  acc_t build_acc;
  acc_t build_acc_next;

  assign bus.sym_rdy      = ready_reg && ena && (!out_vld_reg || bus.out_rdy);
  assign bus.out_vld      = out_vld_reg;
  assign bus.table_ready  = ready_reg;
  assign bus.s_count      = s_count_reg;
  assign bus.s_cumulative = s_cum_reg;
  assign bus.total_count  = total_reg;
`ifdef ANS_ZERO_CHECK_EN
  assign bus.sym_err      = sym_err_reg;
`endif

  // cfg_clr overrides every other action in the same cycle.
  assign load_we = (state_reg == ST_LOAD) && ena && bus.cfg_we && !bus.cfg_clr;
  assign start   = (state_reg == ST_LOAD) && ena && bus.cfg_done && !bus.cfg_clr;
  assign step    = (state_reg == ST_BUILD) && ena && !bus.cfg_clr;
  assign accept  = bus.sym_vld && bus.sym_rdy && !bus.cfg_clr;

  ans_prefix_builder u_builder (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .step     (step),
    .count_in (count_mem[build_idx]),
    .index    (build_idx),
    .acc      (build_acc),
    .acc_next (build_acc_next),
    .done     (done)
  );

  for (genvar gi = 0; gi < NSYM; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_mem[gi] <= '0;
      end else if (load_we && (bus.cfg_sym == sym_t'(gi))) begin
        count_mem[gi] <= bus.cfg_count;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cum_mem[gi] <= '0;
      end else if (step && (build_idx == sym_t'(gi))) begin
        cum_mem[gi] <= build_acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_LOAD;
      out_vld_reg <= 1'b0;
      ready_reg   <= 1'b0;
      s_count_reg <= '0;
      s_cum_reg   <= '0;
      total_reg   <= '0;
`ifdef ANS_ZERO_CHECK_EN
      sym_err_reg <= 1'b0;
`endif
    end else if (bus.cfg_clr) begin
      state_reg   <= ST_LOAD;
      out_vld_reg <= 1'b0;
      ready_reg   <= 1'b0;
`ifdef ANS_ZERO_CHECK_EN
      sym_err_reg <= 1'b0;
`endif
    end else if (ena) begin
      case (state_reg)
        ST_LOAD: begin
          if (bus.cfg_done) begin
            state_reg <= ST_BUILD;
          end
        end
        ST_BUILD: begin
          if (done) begin
            state_reg <= ST_RUN;
            ready_reg <= 1'b1;
            total_reg <= fit_total(build_acc_next);
          end
        end
        ST_RUN: begin
          if (accept) begin
            out_vld_reg <= 1'b1;
            s_count_reg <= count_mem[bus.sym_in];
            s_cum_reg   <= cum_mem[bus.sym_in];
`ifdef ANS_ZERO_CHECK_EN
            if (count_mem[bus.sym_in] == '0) begin
              sym_err_reg <= 1'b1;
            end
`endif
          end else if (bus.out_rdy) begin
            out_vld_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_LOAD;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ans_freq_table.sv
// Self-checking bench for ans_freq_table: table-driven symbol vectors scored
// through an expected-output queue, plus hand sequences for stall/clear/build.
module tb_ans_freq_table;
  import ans_freq_table_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  ans_freq_table_if ifc ();

  ans_freq_table dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sym;
    logic [3:0] cnt;
    logic [5:0] cum;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] sbq[$];
  int         model_cnt[NSYM];
  vec_t       tab1[4];
  vec_t       tab2[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] model_exp(input int s);
    int cum;
    cum = 0;
    for (int k = 0; k < s; k++) cum += model_cnt[k];
    return {4'(model_cnt[s]), 6'(cum)};
  endfunction

  // One clock: score any output consumed at the coming edge, then settle past it.
  task automatic tick();
    logic [9:0] e;
    @(negedge clk);
    if (rst_n && ifc.out_vld && ifc.out_rdy) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got count %0d cum %0d with nothing expected",
                 ifc.s_count, ifc.s_cumulative);
      end else begin
        e = sbq.pop_front();
        check("out_count", 32'(ifc.s_count), 32'(e[9:6]));
        check("out_cum", 32'(ifc.s_cumulative), 32'(e[5:0]));
        $display("out sym-result count=%0d cum=%0d", ifc.s_count, ifc.s_cumulative);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sym(input int s, input bit vld, input bit ordy, input logic [9:0] exp);
    ifc.sym_in  = sym_t'(s);
    ifc.sym_vld = vld;
    ifc.out_rdy = ordy;
    #1;
    if (vld && ifc.sym_rdy) sbq.push_back(exp);
    tick();
  endtask

  task automatic write_cnt(input int s, input int c, input bit upd);
    ifc.cfg_we    = 1'b1;
    ifc.cfg_sym   = sym_t'(s);
    ifc.cfg_count = cnt_t'(c);
    if (upd) model_cnt[s] = c;
    tick();
    ifc.cfg_we = 1'b0;
  endtask

  // Pulse cfg_done (optionally with a final write), then count edges to RUN.
  task automatic build(input int gap, input int exp_cyc, input bit we, input int s, input int c);
    int n;
    ifc.cfg_done  = 1'b1;
    ifc.cfg_we    = we;
    ifc.cfg_sym   = sym_t'(s);
    ifc.cfg_count = cnt_t'(c);
    if (we) model_cnt[s] = c;
    tick();
    ifc.cfg_done = 1'b0;
    ifc.cfg_we   = 1'b0;
    ifc.sym_vld  = 1'b1;
    #1;
    check("sym_rdy_in_build", 32'(ifc.sym_rdy), 32'd0);
    ifc.sym_vld = 1'b0;
    n = 0;
    while (!ifc.table_ready && n < 30) begin
      ena = (n < gap) ? 1'b0 : 1'b1;
      tick();
      n++;
    end
    ena = 1'b1;
    check("build_cycles", 32'(n), 32'(exp_cyc));
    $display("build done after %0d cycles total_count=%0d", n, ifc.total_count);
  endtask

  initial begin
    tab1[0] = '{sym: 2'd3, cnt: 4'd4, cum: 6'd4};
    tab1[1] = '{sym: 2'd0, cnt: 4'd3, cum: 6'd0};
    tab1[2] = '{sym: 2'd1, cnt: 4'd1, cum: 6'd3};
    tab1[3] = '{sym: 2'd2, cnt: 4'd0, cum: 6'd4};
    tab2[0] = '{sym: 2'd2, cnt: 4'd1, cum: 6'd2};
    tab2[1] = '{sym: 2'd0, cnt: 4'd1, cum: 6'd0};
    tab2[2] = '{sym: 2'd3, cnt: 4'd1, cum: 6'd3};
    tab2[3] = '{sym: 2'd1, cnt: 4'd1, cum: 6'd1};
    for (int k = 0; k < NSYM; k++) model_cnt[k] = 0;

    rst_n         = 1'b0;
    ena           = 1'b1;
    ifc.cfg_we    = 1'b0;
    ifc.cfg_sym   = '0;
    ifc.cfg_count = '0;
    ifc.cfg_done  = 1'b0;
    ifc.cfg_clr   = 1'b0;
    ifc.sym_in    = '0;
    ifc.sym_vld   = 1'b0;
    ifc.out_rdy   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_vld", 32'(ifc.out_vld), 32'd0);
    check("rst_table_ready", 32'(ifc.table_ready), 32'd0);
    check("rst_sym_rdy", 32'(ifc.sym_rdy), 32'd0);
    check("rst_total", 32'(ifc.total_count), 32'd0);
    check("rst_s_count", 32'(ifc.s_count), 32'd0);
    check("rst_s_cum", 32'(ifc.s_cumulative), 32'd0);
`ifdef ANS_ZERO_CHECK_EN
    check("rst_sym_err", 32'(ifc.sym_err), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Counts {3,1,0,4}; entry 1 rewritten (last wins), entry 3 written with cfg_done.
    write_cnt(1, 7, 1'b1);
    write_cnt(0, 3, 1'b1);
    write_cnt(1, 1, 1'b1);
    write_cnt(2, 0, 1'b1);
    build(0, 4, 1'b1, 3, 4);
    check("total_8", 32'(ifc.total_count), 32'd8);

    // Back-to-back symbols with out_rdy held high.
    for (int i = 0; i < 4; i++) begin
      drive_sym(int'(tab1[i].sym), 1'b1, 1'b1, {tab1[i].cnt, tab1[i].cum});
      check("out_vld_b2b", 32'(ifc.out_vld), 32'd1);
    end
    drive_sym(0, 1'b0, 1'b1, 10'd0);
    check("out_vld_drained", 32'(ifc.out_vld), 32'd0);
`ifdef ANS_ZERO_CHECK_EN
    check("sym_err_set", 32'(ifc.sym_err), 32'd1);
`endif

    // Downstream stall with symbol 1 held.
    drive_sym(1, 1'b1, 1'b0, model_exp(1));
    for (int i = 0; i < 2; i++) begin
      ifc.out_rdy = 1'b0;
      ifc.sym_vld = 1'b1;
      #1;
      check("stall_sym_rdy", 32'(ifc.sym_rdy), 32'd0);
      check("stall_out_vld", 32'(ifc.out_vld), 32'd1);
      check("stall_count", 32'(ifc.s_count), 32'd1);
      check("stall_cum", 32'(ifc.s_cumulative), 32'd3);
      tick();
    end
    drive_sym(1, 1'b1, 1'b1, model_exp(1));
    drive_sym(0, 1'b0, 1'b1, 10'd0);

    // A write in RUN must not reach the table.
    write_cnt(0, 9, 1'b0);

    // Clear while an output is stalled.
    drive_sym(0, 1'b1, 1'b0, model_exp(0));
    ifc.cfg_clr = 1'b1;
    ifc.sym_vld = 1'b0;
    tick();
    ifc.cfg_clr = 1'b0;
    sbq.delete();
    check("clr_out_vld", 32'(ifc.out_vld), 32'd0);
    check("clr_table_ready", 32'(ifc.table_ready), 32'd0);
    check("clr_sym_rdy", 32'(ifc.sym_rdy), 32'd0);
    check("clr_total_kept", 32'(ifc.total_count), 32'd8);
`ifdef ANS_ZERO_CHECK_EN
    check("clr_sym_err", 32'(ifc.sym_err), 32'd0);
`endif

    // Rebuild with {1,1,1,1}, enable dropped for 3 cycles inside BUILD.
    write_cnt(0, 1, 1'b1);
    write_cnt(1, 1, 1'b1);
    write_cnt(2, 1, 1'b1);
    build(3, 7, 1'b1, 3, 1);
    check("total_4", 32'(ifc.total_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive_sym(int'(tab2[i].sym), 1'b1, 1'b1, {tab2[i].cnt, tab2[i].cum});
    end
    drive_sym(0, 1'b0, 1'b1, 10'd0);

    // Rebuild from retained counts without any writes.
    ifc.cfg_clr = 1'b1;
    tick();
    ifc.cfg_clr = 1'b0;
    build(0, 4, 1'b0, 0, 0);
    check("total_retained", 32'(ifc.total_count), 32'd4);
    drive_sym(3, 1'b1, 1'b1, model_exp(3));
    drive_sym(0, 1'b1, 1'b1, model_exp(0));
    drive_sym(0, 1'b0, 1'b1, 10'd0);
    check("queue_empty", 32'(sbq.size()), 32'd0);

    // Reset in the middle of a stalled handshake.
    drive_sym(2, 1'b1, 1'b0, model_exp(2));
    rst_n = 1'b0;
    #1;
    sbq.delete();
    check("rst2_out_vld", 32'(ifc.out_vld), 32'd0);
    check("rst2_table_ready", 32'(ifc.table_ready), 32'd0);
    check("rst2_s_count", 32'(ifc.s_count), 32'd0);
    check("rst2_total", 32'(ifc.total_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
